uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Downstream buffer for the UART receiver. Detects byte completion on the receiver's
//  rx_ready (0->1 transition) and pushes the received byte into a DEPTH-entry FIFO.
//  Presents bytes to the consumer through a show-ahead valid/ready interface.
//  Decouples the bursty UART byte stream from slower or stalled consumers; flags loss.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of 2, >=2
//  ADDR_W  4   log2(DEPTH); pointer width (count width = ADDR_W+1)
// PORTS
//  baud_clk      in   1         clock; all state on rising edge
//  rst           in   1         reset, asynchronous, active-high
//  rx_ready      in   1         receiver idle/done flag (1=idle, 0=frame in progress)
//  rx_data       in   8         receiver byte output; stable from 1 cycle after rx_ready rises
//  out_valid     out  1         FIFO non-empty; out_data valid
//  out_data      out  8         head-of-FIFO byte (show-ahead)
//  out_ready     in   1         consumer accepts out_data this cycle
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  full          out  1         count==DEPTH
//  overflow      out  1         sticky: >=1 byte dropped
//  overflow_clr  in   1         clears overflow
//  drop_count    out  8         dropped-byte counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: rdy_q=1, wr_pend=0, wr_ptr=rd_ptr=0, count=0, out_valid=0, full=0, overflow=0,
//   drop_count=0; out_data undefined while out_valid=0. Memory contents not reset.
//  rdy_q resets to 1 so the receiver's reset-high rx_ready gives no spurious push.
//  Edge detect: rise = rx_ready & ~rdy_q; rdy_q <= rx_ready every cycle.
//  Capture: rise at cycle N sets wr_pend at N+1; at N+1 rx_data is sampled and pushed.
//   Push latency rx_ready-rise -> out_valid = 2 cycles (empty FIFO).
//  Two-state write FSM: IDLE (wr_pend=0) -> PEND on rise; PEND -> IDLE unconditionally.
//   A rise while in PEND is a new frame; it is honoured (PEND held, second push next cycle).
//  Pop: pop = out_valid & out_ready; rd_ptr <= rd_ptr+1 (mod DEPTH).
//  Push: push = wr_pend & (~full | pop); mem[wr_ptr] <= rx_data; wr_ptr <= wr_ptr+1 (mod DEPTH).
//  count: +1 push only, -1 pop only, unchanged for both or neither. Pointers wrap silently.
//  Empty + push: no same-cycle bypass; out_valid rises the cycle after the push.
//  Empty + out_ready: no effect. Full + push + pop same cycle: both accepted, count stays DEPTH.
//  Full + wr_pend, no pop: byte dropped, FIFO unchanged, overflow <= 1.
//  overflow_clr and new drop same cycle: overflow stays 1 (set wins).
//  out_data = mem[rd_ptr]; holds while out_valid & ~out_ready.
//  Reset mid-operation: all state to reset values immediately; a pending byte is lost.
// CONFIGURATION
//  Macro UART_RX_FIFO_DROPCNT_EN:
//   defined: drop_count increments on each dropped byte; saturates at 8'hFF;
//            cleared by overflow_clr (a drop in the same cycle leaves drop_count=1).
//   undefined: drop_count tied to 8'h00; no counter logic; overflow unaffected.
// TESTING
//  1 rst pulse, rx_ready=1 held -> count=0, out_valid=0, no push after rst release.
//  2 rx_ready 0->1 with rx_data=8'hA5 -> out_valid=1, out_data=8'hA5 2 cycles after rise;
//    out_ready=1 one cycle -> count=0, out_valid=0.
//  3 push 8'h00..8'h13 (20 bytes), out_ready=0, DEPTH=16 -> full=1, count=16, overflow=1,
//    drop_count=4 (macro on) / 0 (off); drain -> bytes 8'h00..8'h0F in order.
//  4 full FIFO, out_ready=1 in the push cycle of 8'h55 -> count stays 16, overflow stays 0,
//    8'h55 read out last.
//  5 overflow=1, pulse overflow_clr -> overflow=0, drop_count=0; clr with drop same cycle
//    -> overflow=1, drop_count=1.
//  6 50 bytes with random out_ready -> pointer wrap; output order matches input, no loss.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Downstream byte buffer for the UART receiver. A 0->1 edge on
//               rx_ready marks a completed frame; the byte on rx_data is
//               captured one cycle later and pushed into a DEPTH-entry FIFO.
//               The consumer side is show-ahead valid/ready. Bytes arriving
//               while the FIFO is full are dropped and flagged (sticky).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        FIFO entries, power of two, >= 2
//   ADDR_W       log2(DEPTH); count is ADDR_W+1 bits wide
// Ports
//   baud_clk     in   1         clock, all state on rising edge
//   rst          in   1         asynchronous active-high reset
//   rx_ready     in   1         receiver idle flag (rises at end of frame)
//   rx_data      in   8         received byte, valid from 1 cycle after rise
//   out_valid    out  1         FIFO non-empty, out_data valid
//   out_data     out  8         head-of-FIFO byte (show-ahead)
//   out_ready    in   1         consumer accepts out_data this cycle
//   count        out  ADDR_W+1  occupancy, 0..DEPTH
//   full         out  1         count == DEPTH
//   overflow     out  1         sticky: at least one byte dropped
//   overflow_clr in   1         clears overflow (and drop_count)
//   drop_count   out  8         dropped-byte counter
// Build option
//   UART_RX_FIFO_DROPCNT_EN : when defined, drop_count counts dropped bytes
//                             (saturating at 8'hFF); otherwise tied to 0.
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [7:0]        drop_count
);

  localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

  // --------------------------------------------------------------------------
  // Write-side FSM: IDLE until a frame completes, then PEND for the cycle in
  // which rx_data is sampled.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } wr_state_t;

  wr_state_t r_state;
  wr_state_t w_state_nxt;

  logic r_rdy_q;
  logic w_rise;
  logic w_wr_pend;

  // rdy_q resets high so a receiver that also comes out of reset idle
  // (rx_ready=1) does not look like a completed frame.
  assign w_rise = rx_ready & ~r_rdy_q;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_rdy_q <= 1'b1;
      r_state <= ST_IDLE;
    end else begin
      r_rdy_q <= rx_ready;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_pend   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        w_wr_pend = 1'b1;
        // A fresh rise while pending is a new frame: stay pending so the
        // second byte is pushed on the following cycle.
        w_state_nxt = w_rise ? ST_PEND : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_valid;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = w_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_wr_pend & (~w_full | w_pop);
  assign w_drop  = w_wr_pend & w_full & ~w_pop;

  // Storage is deliberately not reset; out_data is only meaningful while
  // out_valid is high.
  always_ff @(posedge baud_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky loss flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Optional dropped-byte counter
  // --------------------------------------------------------------------------
`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= 8'h00;
    end else if (overflow_clr) begin
      // Clear and count together: the coincident drop is the first one
      // after the clear.
      r_drop_count <= w_drop ? 8'h01 : 8'h00;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'h01;
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid = w_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
